// File: rtl/sram_fifo_pkg.sv
// Shared constants and types for the SRAM-backed streaming FIFO controller.
//   DATA_WIDTH : word width, matches the 13x128 macro
//   ADDR_WIDTH : macro address width
//   DEPTH      : number of SRAM entries
//   CNT_WIDTH  : width of an occupancy value spanning 0..DEPTH+2
package sram_fifo_pkg;

  localparam int DATA_WIDTH = 13;
  localparam int ADDR_WIDTH = 7;
  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam int CNT_WIDTH  = $clog2(DEPTH + 3);

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;
  typedef logic [CNT_WIDTH-1:0]  cnt_t;

endpackage

// File: rtl/sram_fifo_obuf.sv
// Two-entry circular output buffer that holds words captured from the macro
// read port and presents the oldest one to the consumer.
//   clk     in  : clock
//   rst_n   in  : synchronous active-low reset (clears indices and occupancy)
//   i_push  in  : write i_din into the buffer at this edge
//   i_din   in  : word to store
//   i_pop   in  : drop the head word at this edge
//   o_dout  out : head word
//   o_cnt   out : occupancy, 0..2
module sram_fifo_obuf
  import sram_fifo_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_push,
  input  word_t      i_din,
  input  logic       i_pop,
  output word_t      o_dout,
  output logic [1:0] o_cnt
);

  word_t      r_mem [2];
  logic       r_wr_idx;
  logic       r_rd_idx;
  logic [1:0] r_cnt;

  // Storage needs no reset: occupancy alone decides what is valid.
  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (i_push && (r_wr_idx == 1'(gi))) begin
        r_mem[gi] <= i_din;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_idx <= 1'b0;
      r_rd_idx <= 1'b0;
      r_cnt    <= 2'd0;
    end else begin
      if (i_push) begin
        r_wr_idx <= ~r_wr_idx;
      end
      if (i_pop) begin
        r_rd_idx <= ~r_rd_idx;
      end
      r_cnt <= r_cnt + 2'(i_push) - 2'(i_pop);
    end
  end

  assign o_dout = r_mem[r_rd_idx];
  assign o_cnt  = r_cnt;

endmodule

// File: rtl/freepdk45_sram_fifo_ctrl_13x128.sv
// Streaming FIFO controller wrapped around a 1w1r 13x128 SRAM macro.
// Input words are written straight into the macro; words are read back one
// cycle after they land and captured into a 2-entry output buffer, giving an
// in-order valid/ready stream at one word per cycle. Capacity is DEPTH+2.
//   clk        in  : clock, also drives macro clk0/clk1
//   rst_n      in  : synchronous active-low reset
//   in_valid   in  : input word offered
//   in_ready   out : controller can accept
//   in_data    in  : input word
//   out_valid  out : output head valid
//   out_ready  in  : consumer takes head
//   out_data   out : output head word
//   count      out : words held (SRAM + in-flight + output buffer)
//   sram_csb0  out : macro write chip select, active low
//   sram_addr0 out : macro write address
//   sram_din0  out : macro write data
//   sram_csb1  out : macro read chip select, active low
//   sram_addr1 out : macro read address
//   sram_dout1 in  : macro read data
module freepdk45_sram_fifo_ctrl_13x128
  import sram_fifo_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 sram_csb0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  output logic                 sram_csb1,
  output logic [ADDR_WIDTH-1:0] sram_addr1,
  input  logic [DATA_WIDTH-1:0] sram_dout1
);

  addr_t      r_wr_ptr;
  addr_t      r_rd_ptr;
  cnt_t       r_sram_cnt;
  logic       r_rd_inflight;

  logic       w_in_ready;
  logic       w_push;
  logic       w_ob_valid;
  logic       w_pop;
  logic       w_rd_go;
  logic [2:0] w_occ;
  logic [1:0] w_ob_cnt;
  word_t      w_ob_dout;

  assign w_in_ready = rst_n && (r_sram_cnt < cnt_t'(DEPTH));
  assign w_push     = in_valid && w_in_ready;

  assign w_ob_valid = rst_n && (w_ob_cnt != 2'd0);
  assign w_pop      = w_ob_valid && out_ready;

  // Output-side slots already committed: buffered words plus a read whose
  // data arrives at the next edge. A pop this cycle frees one slot, which is
  // what lets a full buffer keep streaming without a bubble.
  assign w_occ   = {1'b0, w_ob_cnt} + {2'b00, r_rd_inflight};
  // Registered sram_cnt only: a word written this edge is not yet in the
  // macro (it writes on the falling edge), so it is read one cycle later.
  assign w_rd_go = rst_n && (r_sram_cnt != '0) && (w_occ < (3'd2 + {2'b00, w_pop}));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_sram_cnt    <= '0;
      r_rd_inflight <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + addr_t'(1);
      end
      if (w_rd_go) begin
        r_rd_ptr <= r_rd_ptr + addr_t'(1);
      end
      r_sram_cnt    <= r_sram_cnt + cnt_t'(w_push) - cnt_t'(w_rd_go);
      r_rd_inflight <= w_rd_go;
    end
  end

  // Macro dout1 is only stable at the edge after a read, so capture is
  // driven directly by the in-flight flag. A reset edge clears the buffer,
  // which discards any read still in flight.
  sram_fifo_obuf u_obuf (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_push (r_rd_inflight),
    .i_din  (sram_dout1),
    .i_pop  (w_pop),
    .o_dout (w_ob_dout),
    .o_cnt  (w_ob_cnt)
  );

  assign in_ready   = w_in_ready;
  assign out_valid  = w_ob_valid;
  assign out_data   = w_ob_dout;
  assign count      = rst_n ? (r_sram_cnt + cnt_t'(r_rd_inflight) + cnt_t'(w_ob_cnt)) : '0;

  assign sram_csb0  = !w_push;
  assign sram_addr0 = r_wr_ptr;
  assign sram_din0  = in_data;
  assign sram_csb1  = !w_rd_go;
  assign sram_addr1 = r_rd_ptr;

endmodule

// File: tb/tb_freepdk45_sram_fifo_ctrl_13x128.sv
module tb_freepdk45_sram_fifo_ctrl_13x128;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [12:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] out_data;
  logic [7:0]  count;
  logic        sram_csb0;
  logic [6:0]  sram_addr0;
  logic [12:0] sram_din0;
  logic        sram_csb1;
  logic [6:0]  sram_addr1;
  logic [12:0] sram_dout1;

  freepdk45_sram_fifo_ctrl_13x128 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .count      (count),
    .sram_csb0  (sram_csb0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_csb1  (sram_csb1),
    .sram_addr1 (sram_addr1),
    .sram_dout1 (sram_dout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 1w1r macro: write on the falling edge, registered read.
  logic [12:0] mem [128];
  always @(negedge clk) if (!sram_csb0) mem[sram_addr0] <= sram_din0;
  always @(posedge clk) if (!sram_csb1) sram_dout1 <= mem[sram_addr1];

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int pops_win = 0;
  int first_cyc = 0;
  int last_cyc  = 0;
  int out_num   = 0;
  logic [12:0] exp_q [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard: handshakes are decided mid-cycle and take effect at
  // the next rising edge. Expected count is the number of words accepted and
  // not yet delivered.
  always @(negedge clk) begin
    logic [12:0] exp_w;
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      chk("rst_count", int'(count), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_csb0", int'(sram_csb0), 1);
      chk("rst_csb1", int'(sram_csb1), 1);
    end else begin
      chk("count", int'(count), exp_q.size());
      chk("count_le_130", int'(count <= 8'd130), 1);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_output", int'(out_data), -1);
        end else begin
          exp_w = exp_q.pop_front();
          chk("out_data", int'(out_data), int'(exp_w));
          out_num++;
          $display("out #%0d data=0x%04h exp=0x%04h count=%0d", out_num, out_data, exp_w, count);
          if (pops_win == 0) first_cyc = cyc;
          last_cyc = cyc;
          pops_win++;
        end
      end
      if (in_valid && in_ready) exp_q.push_back(in_data);
    end
  end

  task automatic push_word(input logic [12:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 400) begin
      tick();
      n++;
    end
    chk("push_timeout", int'(in_ready), 1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    chk("drain_timeout", exp_q.size(), 0);
    out_ready = 1'b0;
  endtask

  initial begin
    int sent;
    int n;
    logic acc;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;

    // 1: reset, with a word offered that must not be taken
    in_valid = 1'b1; in_data = 13'h0123;
    repeat (3) tick();
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", int'(in_ready), 1);
    chk("post_rst_out_valid", int'(out_valid), 0);

    // 2: single word latency
    tick();
    in_valid = 1'b1; in_data = 13'h0A5A;
    tick();                               // E: accepted
    in_valid = 1'b0;
    @(negedge clk); chk("lat_e", int'(out_valid), 0);
    tick();                               // E+1: read issued
    @(negedge clk); chk("lat_e1", int'(out_valid), 0);
    tick();                               // E+2: captured
    @(negedge clk);
    chk("lat_e2_valid", int'(out_valid), 1);
    chk("lat_e2_data", int'(out_data), 'h0A5A);
    chk("lat_e2_count", int'(count), 1);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    chk("single_pop_count", int'(count), 0);
    chk("single_pop_valid", int'(out_valid), 0);

    // 3: fill to capacity then drain in order
    tick();
    for (int i = 0; i < 130; i++) push_word(13'(i));
    repeat (3) tick();
    @(negedge clk);
    chk("full_count", int'(count), 130);
    chk("full_in_ready", int'(in_ready), 0);
    chk("full_out_valid", int'(out_valid), 1);
    tick();
    wait_drain(1000);
    @(negedge clk);
    chk("drained_count", int'(count), 0);

    // 4: streaming, one word per cycle
    tick();
    pops_win = 0; sent = 0; n = 0;
    in_data = 13'd0; in_valid = 1'b1; out_ready = 1'b1;
    while (sent < 1000 && n < 3000) begin
      acc = in_valid && in_ready;
      tick();
      n++;
      if (acc) begin
        sent++;
        in_data = 13'(sent);
      end
      if (sent == 1000) in_valid = 1'b0;
    end
    chk("stream_sent", sent, 1000);
    wait_drain(100);
    chk("stream_pops", pops_win, 1000);
    chk("stream_no_bubble", last_cyc - first_cyc, 999);

    // 5: random valid/ready across pointer wraps, heavy backpressure first
    tick();
    sent = 0; n = 0;
    in_data = 13'($urandom);
    while (sent < 400 && n < 8000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = (sent < 250) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      acc = in_valid && in_ready;
      tick();
      n++;
      if (acc) begin
        sent++;
        in_data = 13'($urandom);
      end
    end
    in_valid = 1'b0;
    chk("rand_sent", sent, 400);
    wait_drain(1000);

    // 6: reset while a read is in flight; the stale word must vanish
    tick();
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 13'h0777;
    tick();                               // accepted
    in_valid = 1'b0;
    tick();                               // read issued
    rst_n = 1'b0;
    tick();                               // reset edge discards capture
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_count", int'(count), 0);
    chk("midrst_valid", int'(out_valid), 0);
    tick();
    @(negedge clk);
    chk("midrst_valid_later", int'(out_valid), 0);
    tick();
    push_word(13'h1FFF);
    repeat (3) tick();
    @(negedge clk);
    chk("post_rst_head", int'(out_data), 'h1FFF);
    tick();
    wait_drain(20);
    @(negedge clk);
    chk("final_count", int'(count), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
